ram_sequencer: RTL and testbench
================================

Name: ram_sequencer

Overview:
- Initiator/master for the 256x16 single-port synchronous RAM block.
- Drives the RAM's write, addr and data_in, and consumes its registered data_out.
- Two operations over an inclusive, wrapping address range: FILL writes an incrementing pattern; SCAN reads back every word, streams it out with a valid strobe and accumulates a 16-bit sum.
- Sits between the control FSM and the RAM instance.

Parameters:
- AW, 8, RAM address width (range and wrap modulo 2^AW).
- DW, 16, RAM data width (pattern and sum modulo 2^DW).

Ports:
- sysclk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  1  0 = FILL, 1 = SCAN; sampled with start.
- abort  in  1  synchronous stop of the current operation.
- base_addr  in  AW  first address; sampled with start.
- last_addr  in  AW  final address, inclusive; sampled with start.
- fill_value  in  DW  pattern seed; sampled with start.
- ram_write  out  1  to RAM write.
- ram_addr  out  AW  to RAM addr.
- ram_data_in  out  DW  to RAM data_in.
- ram_data_out  in  DW  from RAM data_out; reflects the address sampled at the previous edge.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse after an abort.
- rd_valid  out  1  rd_data/rd_addr valid this cycle (SCAN only).
- rd_data  out  DW  word read.
- rd_addr  out  AW  address of rd_data.
- sum  out  DW  running sum of words written or read; holds after completion until the next start.

Behaviour:
- Reset: clock and reset are as already decided — one clock, sysclk; reset is asynchronous and active-high.
  - Reset immediately forces state IDLE.
  - All outputs go to 0: ram_write, ram_addr, ram_data_in, busy, done, aborted, rd_valid, rd_data, rd_addr, sum.
  - Reset mid-operation truncates it silently: no done, no aborted pulse.
- Outputs are registered.
- Range: count = ((last_addr - base_addr) mod 2^AW) + 1, so 1..256 words.
  - base == last gives 1 word.
  - base == last+1 gives 256 words.
  - Addresses increment modulo 2^AW and wrap from 255 to 0.
- States: IDLE, FILL, SCAN, DRAIN, DONE.
- IDLE:
  - start=1 at edge E0: latch the inputs, clear sum to 0, set busy=1.
  - Go to FILL (mode=0) or SCAN (mode=1).
  - start while busy is ignored.
- FILL:
  - From E0, each edge presents one word: ram_write=1, ram_addr=base+i, ram_data_in=(fill_value+i) mod 2^DW, for i=0..count-1.
  - sum accumulates each data word as it is presented.
  - ram_write is high for exactly count consecutive cycles.
  - At the edge after the last word: ram_write=0, busy=0, done=1 for one cycle (state DONE), then IDLE.
- SCAN:
  - ram_write stays 0 throughout.
  - ram_addr=base+i is issued at edge E0+i, for i=0..count-1.
  - The RAM samples the address at E0+i+1.
  - The block captures ram_data_out at E0+i+2, registering rd_valid=1, rd_data, rd_addr=base+i, and sum += rd_data.
  - A 2-stage valid/address tag pipeline tracks outstanding reads.
  - After the last issue, state is DRAIN until the pipeline is empty.
  - The last rd_valid is at E0+count+1; rd_valid is high for count consecutive cycles.
  - done=1 and busy=0 at E0+count+2; done lasts one cycle.
- Abort (synchronous, any non-IDLE state):
  - Next edge: ram_write=0, no further issues, in-flight SCAN tags discarded (no rd_valid after that edge).
  - busy=0, aborted=1 for one cycle, done not asserted, sum holds its partial value.
  - abort and start in the same IDLE cycle: start wins, abort ignored.
- ram_addr holds its last value when not issuing; ram_data_in is don't-care when ram_write=0.
- Arithmetic:
  - sum and pattern wrap modulo 2^DW.
  - No overflow flag.

Test Plan:
- FILL base=0x10 last=0x13 fill=0x0100 → ram_write high 4 cycles; addr 10..13; data 0100..0103; done 1 cycle later; sum=0x0406.
- SCAN of the same range after that FILL → rd_valid 4 consecutive cycles starting 2 cycles after the start edge; rd_data 0100..0103 with rd_addr 10..13; done the cycle after the last valid; sum=0x0406.
- FILL then SCAN base=0xFE last=0x01, fill=0xFFFF → addresses FE,FF,00,01; data FFFF,0000,0001,0002; sum=0x0002 (wrapped).
- Full range base=0x00 last=0xFF → 256 words; SCAN busy high for 258 cycles; base==last → exactly 1 word.
- abort asserted 2 cycles into a 10-word SCAN → at most 1 rd_valid, then aborted pulse, no done; start pulses during busy are ignored.
- Async reset asserted mid-FILL between clock edges → ram_write and busy drop to 0 without a clock edge; the next start runs normally.

Source files
------------

// File: rtl/ram_sequencer_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : ram_sequencer_if
// Description : Bus between the RAM sequencer (master) and the 256x16
//               single-port synchronous RAM (slave).
//               ram_write    - write enable, master -> RAM
//               ram_addr     - word address, master -> RAM
//               ram_data_in  - write data, master -> RAM
//               ram_data_out - registered read data, RAM -> master; reflects
//                              the address sampled at the previous edge
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface ram_sequencer_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic          ram_write;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out;

    modport master (
        output ram_write,
        output ram_addr,
        output ram_data_in,
        input  ram_data_out
    );

    modport slave (
        input  ram_write,
        input  ram_addr,
        input  ram_data_in,
        output ram_data_out
    );
endinterface
`default_nettype wire

// File: rtl/ram_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : ram_sequencer
// Description : Initiator for a single-port synchronous RAM. Runs FILL (write
//               an incrementing pattern) or SCAN (read back, stream out and
//               sum) over an inclusive address range that wraps modulo 2^AW.
// Ports       : sysclk      - clock, rising edge
//               reset       - asynchronous, active-high
//               start/mode  - one-cycle request, mode 0=FILL 1=SCAN (IDLE only)
//               abort       - synchronous stop of the running operation
//               base_addr/last_addr/fill_value - operation arguments
//               ram         - RAM bus (master modport)
//               busy/done/aborted - status; done and aborted are 1-cycle pulses
//               rd_valid/rd_data/rd_addr - SCAN read stream
//               sum         - running sum of words written or read
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module ram_sequencer #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  wire logic          sysclk,
    input  wire logic          reset,
    input  wire logic          start,
    input  wire logic          mode,
    input  wire logic          abort,
    input  wire logic [AW-1:0] base_addr,
    input  wire logic [AW-1:0] last_addr,
    input  wire logic [DW-1:0] fill_value,
    ram_sequencer_if.master    ram,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic               rd_valid,
    output logic [DW-1:0]      rd_data,
    output logic [AW-1:0]      rd_addr,
    output logic [DW-1:0]      sum
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_SCAN  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state;

    // Words still to issue after the one currently on the bus.
    logic [AW-1:0] r_remaining;
    logic [AW-1:0] w_remaining;

    // Read tag pipeline: stage 1 = address issued this edge, stage 2 = address
    // sampled by the RAM; data for a stage-2 tag is on ram_data_out now.
    logic          r_p1_valid;
    logic [AW-1:0] r_p1_addr;
    logic          r_p2_valid;
    logic [AW-1:0] r_p2_addr;
    logic          w_p1_valid;
    logic [AW-1:0] w_p1_addr;
    logic          w_p2_valid;
    logic [AW-1:0] w_p2_addr;

    logic          w_ram_write;
    logic [AW-1:0] w_ram_addr;
    logic [DW-1:0] w_ram_data_in;
    logic          w_busy;
    logic          w_done;
    logic          w_aborted;
    logic          w_rd_valid;
    logic [DW-1:0] w_rd_data;
    logic [AW-1:0] w_rd_addr;
    logic [DW-1:0] w_sum;
    logic          w_abort_now;

    //--------------------------------------------------------------------------
    // State and output registers
    //--------------------------------------------------------------------------
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_remaining     <= '0;
            r_p1_valid      <= 1'b0;
            r_p1_addr       <= '0;
            r_p2_valid      <= 1'b0;
            r_p2_addr       <= '0;
            ram.ram_write   <= 1'b0;
            ram.ram_addr    <= '0;
            ram.ram_data_in <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            aborted         <= 1'b0;
            rd_valid        <= 1'b0;
            rd_data         <= '0;
            rd_addr         <= '0;
            sum             <= '0;
        end else begin
            r_state         <= w_state;
            r_remaining     <= w_remaining;
            r_p1_valid      <= w_p1_valid;
            r_p1_addr       <= w_p1_addr;
            r_p2_valid      <= w_p2_valid;
            r_p2_addr       <= w_p2_addr;
            ram.ram_write   <= w_ram_write;
            ram.ram_addr    <= w_ram_addr;
            ram.ram_data_in <= w_ram_data_in;
            busy            <= w_busy;
            done            <= w_done;
            aborted         <= w_aborted;
            rd_valid        <= w_rd_valid;
            rd_data         <= w_rd_data;
            rd_addr         <= w_rd_addr;
            sum             <= w_sum;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state and next-output logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_state       = r_state;
        w_remaining   = r_remaining;
        w_ram_write   = 1'b0;
        w_ram_addr    = ram.ram_addr;
        w_ram_data_in = ram.ram_data_in;
        w_busy        = busy;
        w_done        = 1'b0;
        w_aborted     = 1'b0;
        w_rd_valid    = 1'b0;
        w_rd_data     = rd_data;
        w_rd_addr     = rd_addr;
        w_sum         = sum;
        w_p1_valid    = 1'b0;
        w_p1_addr     = r_p1_addr;
        w_p2_valid    = r_p1_valid;
        w_p2_addr     = r_p1_addr;

        // DONE has nothing left to stop, so abort is only honoured while working.
        w_abort_now = abort && ((r_state == S_FILL) || (r_state == S_SCAN) ||
                                (r_state == S_DRAIN));

        // Capture the read whose address the RAM sampled at the previous edge.
        if (r_p2_valid && !w_abort_now) begin
            w_rd_valid = 1'b1;
            w_rd_data  = ram.ram_data_out;
            w_rd_addr  = r_p2_addr;
            w_sum      = sum + ram.ram_data_out;
        end

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_sum       = '0;
                    w_busy      = 1'b1;
                    w_remaining = last_addr - base_addr;
                    w_ram_addr  = base_addr;
                    if (!mode) begin
                        w_ram_write   = 1'b1;
                        w_ram_data_in = fill_value;
                        w_state       = S_FILL;
                    end else begin
                        w_p1_valid = 1'b1;
                        w_p1_addr  = base_addr;
                        w_state    = S_SCAN;
                    end
                end
            end

            S_FILL: begin
                // The word on the bus is written at this edge; count it now.
                w_sum = sum + ram.ram_data_in;
                if (r_remaining == '0) begin
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    w_state = S_DONE;
                end else begin
                    w_ram_write   = 1'b1;
                    w_ram_addr    = ram.ram_addr + 1'b1;
                    w_ram_data_in = ram.ram_data_in + 1'b1;
                    w_remaining   = r_remaining - 1'b1;
                end
            end

            S_SCAN: begin
                if (r_remaining == '0) begin
                    w_state = S_DRAIN;
                end else begin
                    w_ram_addr  = ram.ram_addr + 1'b1;
                    w_remaining = r_remaining - 1'b1;
                    w_p1_valid  = 1'b1;
                    w_p1_addr   = ram.ram_addr + 1'b1;
                end
            end

            S_DRAIN: begin
                if (!r_p1_valid && !r_p2_valid) begin
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    w_state = S_DONE;
                end
            end

            S_DONE: begin
                w_state = S_IDLE;
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase

        // Abort overrides normal progress: stop issuing, drop in-flight tags,
        // keep the partial sum (including a FILL word written at this edge).
        if (w_abort_now) begin
            w_state       = S_DONE;
            w_busy        = 1'b0;
            w_done        = 1'b0;
            w_aborted     = 1'b1;
            w_ram_write   = 1'b0;
            w_ram_addr    = ram.ram_addr;
            w_ram_data_in = ram.ram_data_in;
            w_remaining   = r_remaining;
            w_p1_valid    = 1'b0;
            w_p2_valid    = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_ram_sequencer
// Description : Scoreboard bench for ram_sequencer with a behavioural
//               256x16 synchronous RAM on the slave side of the bus.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_ram_sequencer;

    logic        sysclk;
    logic        reset;
    logic        start;
    logic        mode;
    logic        abort;
    logic [7:0]  base_addr;
    logic [7:0]  last_addr;
    logic [15:0] fill_value;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic [7:0]  rd_addr;
    logic [15:0] sum;

    ram_sequencer_if #(.AW(8), .DW(16)) ram_bus ();

    ram_sequencer #(.AW(8), .DW(16)) u_dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .abort      (abort),
        .base_addr  (base_addr),
        .last_addr  (last_addr),
        .fill_value (fill_value),
        .ram        (ram_bus),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_addr    (rd_addr),
        .sum        (sum)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Behavioural RAM: registered read, write on ram_write.
    logic [15:0] mem [256];
    always @(posedge sysclk) begin
        if (ram_bus.ram_write) mem[ram_bus.ram_addr] <= ram_bus.ram_data_in;
        ram_bus.ram_data_out <= mem[ram_bus.ram_addr];
    end

    int          checks = 0;
    int          errors = 0;
    logic [23:0] wq[$];           // expected writes {addr, data}
    logic [23:0] rq[$];           // expected reads  {addr, data}
    logic [15:0] shadow [256];    // bench copy of what FILLs should have stored
    logic [23:0] mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every presented write / read against the queues.
    always @(negedge sysclk) begin
        if (!reset) begin
            if (ram_bus.ram_write) begin
                if (wq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                             ram_bus.ram_addr, ram_bus.ram_data_in);
                end else begin
                    mon_e = wq.pop_front();
                    check("wr_addr", 32'(ram_bus.ram_addr), 32'(mon_e[23:16]));
                    check("wr_data", 32'(ram_bus.ram_data_in), 32'(mon_e[15:0]));
                end
            end
            if (rd_valid) begin
                if (rq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rd_valid: addr 0x%0h data 0x%0h, none expected",
                             rd_addr, rd_data);
                end else begin
                    mon_e = rq.pop_front();
                    check("rd_addr", 32'(rd_addr), 32'(mon_e[23:16]));
                    check("rd_data", 32'(rd_data), 32'(mon_e[15:0]));
                end
            end
        end
    end

    task automatic push_expected(input logic m, input logic [7:0] b, input logic [7:0] l,
                                 input logic [15:0] f, output int cnt);
        logic [7:0]  a;
        logic [7:0]  diff;
        diff = l - b;
        cnt  = int'(diff) + 1;
        for (int i = 0; i < cnt; i++) begin
            a = b + 8'(i);
            if (!m) begin
                wq.push_back({a, f + 16'(i)});
                shadow[a] = f + 16'(i);
            end else begin
                rq.push_back({a, shadow[a]});
            end
        end
    endtask

    task automatic pulse_start(input logic m, input logic [7:0] b, input logic [7:0] l,
                               input logic [15:0] f);
        @(posedge sysclk); #1;
        mode = m; base_addr = b; last_addr = l; fill_value = f; start = 1'b1;
        @(posedge sysclk); #1;   // start edge E0
        start = 1'b0;
    endtask

    task automatic run_op(input logic m, input logic [7:0] b, input logic [7:0] l,
                          input logic [15:0] f, input logic [15:0] exp_sum, input bit poke);
        int cnt;
        int done_at;
        int busy_cycles;
        int exp_lat;
        push_expected(m, b, l, f, cnt);
        pulse_start(m, b, l, f);
        done_at     = -1;
        busy_cycles = 0;
        for (int k = 0; k < cnt + 10; k++) begin
            @(negedge sysclk);
            if (poke && k == 1) begin
                start = 1'b1; mode = ~m; base_addr = 8'h99; last_addr = 8'h99;
            end
            if (poke && k == 2) start = 1'b0;
            if (busy) busy_cycles++;
            if (done) begin
                done_at = k;
                break;
            end
        end
        exp_lat = m ? cnt + 2 : cnt;
        check("done_latency", 32'(done_at), 32'(exp_lat));
        check("busy_cycles", 32'(busy_cycles), 32'(exp_lat));
        check("sum", 32'(sum), 32'(exp_sum));
        check("aborted_at_done", 32'(aborted), 32'd0);
        check("writes_left", 32'(wq.size()), 32'd0);
        check("reads_left", 32'(rq.size()), 32'd0);
        @(negedge sysclk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("sum_hold", 32'(sum), 32'(exp_sum));
        wq.delete();
        rq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        reset = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0;
        base_addr = '0; last_addr = '0; fill_value = '0;
        #3;
        check("rst_ram_write", 32'(ram_bus.ram_write), 32'd0);
        check("rst_ram_addr", 32'(ram_bus.ram_addr), 32'd0);
        check("rst_ram_data_in", 32'(ram_bus.ram_data_in), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_aborted", 32'(aborted), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        @(posedge sysclk); #2;
        reset = 1'b0;

        // Basic FILL with a stray start during busy, then SCAN the same range.
        run_op(1'b0, 8'h10, 8'h13, 16'h0100, 16'h0406, 1'b1);
        run_op(1'b1, 8'h10, 8'h13, 16'h0000, 16'h0406, 1'b0);

        // Wrapping address range and wrapping pattern/sum.
        run_op(1'b0, 8'hFE, 8'h01, 16'hFFFF, 16'h0002, 1'b0);
        run_op(1'b1, 8'hFE, 8'h01, 16'h0000, 16'h0002, 1'b1);

        // Full 256-word range: pattern equals address, sum = 0..255 = 0x7F80.
        run_op(1'b0, 8'h00, 8'hFF, 16'h0000, 16'h7F80, 1'b0);
        run_op(1'b1, 8'h00, 8'hFF, 16'h0000, 16'h7F80, 1'b0);

        // Single word.
        run_op(1'b0, 8'h55, 8'h55, 16'hABCD, 16'hABCD, 1'b0);
        run_op(1'b1, 8'h55, 8'h55, 16'h0000, 16'hABCD, 1'b0);

        // Abort a 10-word SCAN: only the first word (0x0020) reaches rd_valid.
        rq.push_back({8'h20, 16'h0020});
        pulse_start(1'b1, 8'h20, 8'h29, 16'h0000);   // now just after E0
        @(posedge sysclk); #1;                       // E1
        @(posedge sysclk); #1;                       // E2: word 0 valid
        abort = 1'b1;
        @(posedge sysclk); #1;                       // E3: abort taken
        abort = 1'b0;
        check("abort_pulse", 32'(aborted), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_no_done", 32'(done), 32'd0);
        check("abort_rd_valid", 32'(rd_valid), 32'd0);
        check("abort_sum", 32'(sum), 32'h0020);
        @(posedge sysclk); #1;
        check("abort_one_cycle", 32'(aborted), 32'd0);
        check("abort_no_late_done", 32'(done), 32'd0);
        check("abort_reads_left", 32'(rq.size()), 32'd0);
        rq.delete();

        // Asynchronous reset between edges in the middle of a FILL.
        push_expected(1'b0, 8'h40, 8'h4F, 16'h5000, cnt);
        pulse_start(1'b0, 8'h40, 8'h4F, 16'h5000);
        @(posedge sysclk);
        @(posedge sysclk);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_ram_write", 32'(ram_bus.ram_write), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_aborted", 32'(aborted), 32'd0);
        wq.delete();
        @(posedge sysclk); #2;
        reset = 1'b0;

        // Normal operation after reset: 0x1111*4 + 6 = 0x444A.
        run_op(1'b0, 8'h40, 8'h43, 16'h1111, 16'h444A, 1'b0);
        run_op(1'b1, 8'h40, 8'h43, 16'h0000, 16'h444A, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
